// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, request/ready imem port, freeze skid buffer, branch drain.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] pc_inc_s;
  logic        done_s;

  // HOLD parks the request; in DRAIN pc_q still holds the outstanding address
  assign imem_req    = rst & (state_q != ST_HOLD);
  assign imem_addr   = pc_q;
  assign done_s      = imem_req & imem_ready;
  assign pc_inc_s    = pc_q + PC_STEP;
  assign PC          = out_pc_q;
  assign Instruction = out_instr_q;
  assign IF_valid    = out_valid_q;

  // Next-state and IF/ID update logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_FETCH: begin
        if (done_s) begin
          if (Branch_taken) begin
            pc_d        = Branch_Addr;
            out_valid_d = 1'b0;
            out_instr_d = 32'd0;
          end else if (freeze) begin
            buf_d    = imem_rdata;
            buf_pc_d = pc_inc_s;
            pc_d     = pc_inc_s;
            state_d  = ST_HOLD;
          end else begin
            out_pc_d    = pc_inc_s;
            out_instr_d = imem_rdata;
            out_valid_d = 1'b1;
            pc_d        = pc_inc_s;
          end
        end else begin
          if (Branch_taken) begin
            redir_d     = Branch_Addr;
            out_valid_d = 1'b0;
            out_instr_d = 32'd0;
            state_d     = ST_DRAIN;
          end else if (freeze) begin
            out_valid_d = out_valid_q;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        out_valid_d = 1'b0;
        if (Branch_taken) begin
          redir_d = Branch_Addr;
        end else begin
          redir_d = redir_q;
        end
        if (done_s) begin
          pc_d    = Branch_taken ? Branch_Addr : redir_q;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (Branch_taken) begin
          buf_d       = 32'd0;
          pc_d        = Branch_Addr;
          out_valid_d = 1'b0;
          out_instr_d = 32'd0;
          state_d     = ST_FETCH;
        end else if (!freeze) begin
          out_pc_d    = buf_pc_q;
          out_instr_d = buf_q;
          out_valid_d = 1'b1;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_FETCH;
      end
    endcase
  end

  // State, PC, skid buffer and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      redir_q     <= 32'd0;
      buf_q       <= 32'd0;
      buf_pc_q    <= 32'd0;
      out_pc_q    <= 32'd0;
      out_instr_q <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Only completions in FETCH without a same-cycle branch deliver an instruction
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_FETCH) && done_s && !Branch_taken) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (imem_req && !imem_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: directed scenarios push expected IF/ID words,
// a monitor pops and compares whenever a new instruction is loaded into IF/ID.
module tb_if_stage_fetch;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] Branch_Addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        IF_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`else
  // No counter ports in this configuration.
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   mem_wait;
  int   wcnt;
  logic mon_fz;
  logic mon_rs;
  exp_t mon_e;

  if_stage_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .Branch_Addr  (Branch_Addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .PC           (PC),
    .Instruction  (Instruction),
    .IF_valid     (IF_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hE1A0_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc    = a + 32'd4;
    e.instr = memw(a);
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    freeze       = 1'b0;
    Branch_taken = 1'b0;
    Branch_Addr  = 32'd0;
    mem_wait     = 1000;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Memory model: answers mem_wait cycles after a request is first seen
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    wcnt       = 0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req) begin
        if (wcnt >= mem_wait) begin
          imem_ready = 1'b1;
          imem_rdata = memw(imem_addr);
          wcnt       = 0;
        end else begin
          imem_ready = 1'b0;
          imem_rdata = 32'hBAD0_BAD0;
          wcnt++;
        end
      end else begin
        imem_ready = 1'b0;
        wcnt       = 0;
      end
    end
  end

  // Monitor: an unfrozen edge in reset-free operation leaving IF_valid=1 loaded a new word
  initial begin
    forever begin
      @(posedge clk);
      mon_fz = freeze;
      mon_rs = rst;
      #1;
      if (mon_rs && !mon_fz && IF_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ifid actual=%h/%h required=none", PC, Instruction);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ifid_pc", PC, mon_e.pc);
          chk("ifid_instr", Instruction, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    freeze       = 1'b0;
    Branch_taken = 1'b0;
    Branch_Addr  = 32'd0;
    mem_wait     = 1000;

    // Reset state
    cyc(); cyc(); cyc();
    chk("rst_valid", {31'd0, IF_valid}, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait streaming
    do_reset();
    mem_wait = 0;
    push(32'd0); push(32'd4); push(32'd8);
    rst = 1'b1;
    cyc();
    chk("zw_first_valid", {31'd0, IF_valid}, 32'd1);
    chk("zw_first_pc", PC, 32'd4);
    cyc(); cyc();
    mem_wait = 1000;
    chk("zw_sb_empty", 32'(sb_q.size()), 32'd0);

    // Two wait cycles
    do_reset();
    mem_wait = 2;
    push(32'd0);
    rst = 1'b1;
    cyc();
    chk("w2_addr1", imem_addr, 32'd0);
    chk("w2_req1", {31'd0, imem_req}, 32'd1);
    chk("w2_valid1", {31'd0, IF_valid}, 32'd0);
    cyc();
    chk("w2_addr2", imem_addr, 32'd0);
    chk("w2_valid2", {31'd0, IF_valid}, 32'd0);
    cyc();
    chk("w2_valid3", {31'd0, IF_valid}, 32'd1);
    chk("w2_pc", PC, 32'd4);
    mem_wait = 1000;
`ifdef IF_PERF_CNT_EN
    chk("w2_fetch_cnt", fetch_cnt, 32'd1);
    chk("w2_stall_cnt", stall_cnt, 32'd2);
`else
    // Counters not present.
`endif
    chk("w2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Freeze for three cycles across the fetch of address 8
    do_reset();
    mem_wait = 0;
    push(32'd0); push(32'd4); push(32'd8); push(32'd12);
    rst = 1'b1;
    cyc();
    cyc();
    freeze = 1'b1;
    cyc();
    chk("fz_req_hold", {31'd0, imem_req}, 32'd0);
    chk("fz_pc_hold", PC, 32'd8);
    chk("fz_instr_hold", Instruction, memw(32'd4));
    cyc(); cyc();
    chk("fz_pc_hold3", PC, 32'd8);
    chk("fz_req_hold3", {31'd0, imem_req}, 32'd0);
    freeze = 1'b0;
    cyc();
    chk("fz_release_pc", PC, 32'd12);
    chk("fz_release_req", {31'd0, imem_req}, 32'd1);
    cyc();
    mem_wait = 1000;
    chk("fz_sb_empty", 32'(sb_q.size()), 32'd0);

    // Branch during a wait cycle at 0x20
    do_reset();
    mem_wait = 0;
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    rst = 1'b1;
    repeat (8) cyc();
    mem_wait = 1000;
    cyc();
    chk("br_wait_addr", imem_addr, 32'h20);
    chk("br_wait_valid", {31'd0, IF_valid}, 32'd0);
    Branch_taken = 1'b1;
    Branch_Addr  = 32'h100;
    cyc();
    Branch_taken = 1'b0;
    Branch_Addr  = 32'hDEAD_BEE0;
    chk("br_drain_addr", imem_addr, 32'h20);
    chk("br_drain_req", {31'd0, imem_req}, 32'd1);
    chk("br_drain_valid", {31'd0, IF_valid}, 32'd0);
    cyc();
    chk("br_drain_addr2", imem_addr, 32'h20);
    chk("br_drain_valid2", {31'd0, IF_valid}, 32'd0);
    mem_wait = 0;
    cyc();
    chk("br_target_addr", imem_addr, 32'h100);
    chk("br_after_valid", {31'd0, IF_valid}, 32'd0);
    push(32'h100);
    cyc();
    mem_wait = 1000;
    chk("br_target_pc", PC, 32'h104);
    chk("br_sb_empty", 32'(sb_q.size()), 32'd0);

    // Branch and freeze together while in HOLD
    do_reset();
    mem_wait = 0;
    push(32'd0);
    rst = 1'b1;
    cyc();
    freeze = 1'b1;
    cyc();
    chk("hb_req_hold", {31'd0, imem_req}, 32'd0);
    chk("hb_pc_hold", PC, 32'd4);
    Branch_taken = 1'b1;
    Branch_Addr  = 32'h100;
    cyc();
    chk("hb_valid", {31'd0, IF_valid}, 32'd0);
    chk("hb_instr", Instruction, 32'd0);
    chk("hb_addr", imem_addr, 32'h100);
    chk("hb_req", {31'd0, imem_req}, 32'd1);
    Branch_taken = 1'b0;
    freeze       = 1'b0;
    push(32'h100);
    cyc();
    mem_wait = 1000;
    chk("hb_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while waiting at 0x40
    do_reset();
    mem_wait = 0;
    for (int i = 0; i < 16; i++) push(32'(i * 4));
    rst = 1'b1;
    repeat (16) cyc();
    mem_wait = 1000;
    cyc();
    chk("mr_wait_addr", imem_addr, 32'h40);
    chk("mr_wait_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b0;
    cyc();
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_valid", {31'd0, IF_valid}, 32'd0);
    chk("mr_pcreg", imem_addr, 32'd0);
    chk("mr_pc", PC, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("mr_fetch_cnt", fetch_cnt, 32'd0);
    chk("mr_stall_cnt", stall_cnt, 32'd0);
`else
    // Counters not present.
`endif
    mem_wait = 0;
    push(32'd0);
    rst = 1'b1;
    cyc();
    chk("mr_restart_pc", PC, 32'd4);
    chk("mr_restart_addr", imem_addr, 32'd4);
    mem_wait = 1000;
    chk("mr_sb_empty", 32'(sb_q.size()), 32'd0);

    // Branch on a completing fetch to the top of memory, then wrap to 0
    do_reset();
    mem_wait     = 0;
    rst          = 1'b1;
    Branch_taken = 1'b1;
    Branch_Addr  = 32'hFFFF_FFFC;
    cyc();
    Branch_taken = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'd0, IF_valid}, 32'd0);
    push(32'hFFFF_FFFC);
    cyc();
    chk("wr_pc", PC, 32'd0);
    chk("wr_next_addr", imem_addr, 32'd0);
    push(32'd0);
    cyc();
    mem_wait = 1000;
    chk("wr_sb_empty", 32'(sb_q.size()), 32'd0);

    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
